// File: rtl/rvvi_pkg.sv
// Shared types and constants for the RVVI retirement tracer.
// Event fields are sized for the widest legal ILEN/XLEN; narrower builds zero-extend.
package rvvi_pkg;

    localparam int MAX_ILEN = 32;
    localparam int MAX_XLEN = 64;

    localparam logic [1:0] IXL_32 = 2'd1;
    localparam logic [1:0] IXL_64 = 2'd2;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } tracer_state_e;

    typedef struct packed {
        logic [MAX_ILEN-1:0] insn;
        logic [MAX_XLEN-1:0] pc;
        logic [MAX_XLEN-1:0] next_pc;
        logic                trap;
        logic                halt;
        logic [1:0]          mode;
        logic                rd_we;
        logic [4:0]          rd_addr;
        logic [MAX_XLEN-1:0] rd_wdata;
    } retire_event_t;

    // x0 is hardwired, so a write to it never raises a writeback flag.
    function automatic logic [31:0] wb_mask(input logic rd_we, input logic [4:0] rd_addr);
        logic [31:0] mask;
        mask = 32'd0;
        if (rd_we && (rd_addr != 5'd0)) begin
            mask[rd_addr] = 1'b1;
        end else begin
            mask = 32'd0;
        end
        return mask;
    endfunction

endpackage

// File: rtl/rvvi_event_fifo.sv
// Synchronous FIFO of retirement events; pointers carry one extra wrap bit
// so that full and empty are distinguishable.
module rvvi_event_fifo
    import rvvi_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  retire_event_t push_data,
    input  logic          pop,
    output retire_event_t head,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    retire_event_t mem_r [DEPTH];
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_ok_s  = pop & ~empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign push_ok_s = push & (~full | pop_ok_s);
    assign head      = mem_r[rd_ptr_r[AW-1:0]];

    // Read/write pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/rvvi_retire_tracer.sv
// RVVI trace producer: buffers commit-stage retirements and publishes one
// registered RVVI record per pop, maintaining a shadow X file and order count.
module rvvi_retire_tracer
    import rvvi_pkg::*;
#(
    parameter int ILEN       = 32,
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ret_valid,
    output logic                 ret_ready,
    input  logic [ILEN-1:0]      ret_insn,
    input  logic [XLEN-1:0]      ret_pc,
    input  logic [XLEN-1:0]      ret_next_pc,
    input  logic                 ret_trap,
    input  logic                 ret_halt,
    input  logic [1:0]           ret_mode,
    input  logic                 ret_rd_we,
    input  logic [4:0]           ret_rd_addr,
    input  logic [XLEN-1:0]      ret_rd_wdata,
    input  logic                 trc_hold,
    output logic                 rvvi_valid,
    output logic [63:0]          rvvi_order,
    output logic [ILEN-1:0]      rvvi_insn,
    output logic                 rvvi_trap,
    output logic                 rvvi_halt,
    output logic                 rvvi_intr,
    output logic [1:0]           rvvi_mode,
    output logic [1:0]           rvvi_ixl,
    output logic [XLEN-1:0]      rvvi_pc_rdata,
    output logic [XLEN-1:0]      rvvi_pc_wdata,
    output logic [31:0][XLEN-1:0] rvvi_x_wdata,
    output logic [31:0]          rvvi_x_wb
);

    localparam logic [1:0] IXL = (XLEN == 64) ? IXL_64 : IXL_32;

    tracer_state_e         state_r;
    tracer_state_e         state_next_s;
    retire_event_t         push_data_s;
    retire_event_t         head_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  trap_pend_r;
    logic [63:0]           order_cnt_r;
    logic [31:0][XLEN-1:0] shadow_r;
    logic                  unused_hi_s;

    assign ret_ready    = (state_r == RUN) && !fifo_full_s;
    assign push_s       = ret_valid & ret_ready;
    assign pop_s        = !fifo_empty_s && !trc_hold;
    assign rvvi_ixl     = IXL;
    assign rvvi_x_wdata = shadow_r;
    // Upper bits of the max-width event fields are dropped on narrow builds.
    assign unused_hi_s  = ^{head_s.insn, head_s.pc, head_s.next_pc, head_s.rd_wdata};

    // Pack the incoming retirement into the widest event layout.
    always_comb begin
        push_data_s          = '0;
        push_data_s.insn     = MAX_ILEN'(ret_insn);
        push_data_s.pc       = MAX_XLEN'(ret_pc);
        push_data_s.next_pc  = MAX_XLEN'(ret_next_pc);
        push_data_s.trap     = ret_trap;
        push_data_s.halt     = ret_halt;
        push_data_s.mode     = ret_mode;
        push_data_s.rd_we    = ret_rd_we;
        push_data_s.rd_addr  = ret_rd_addr;
        push_data_s.rd_wdata = MAX_XLEN'(ret_rd_wdata);
    end

    rvvi_event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_s),
        .push_data(push_data_s),
        .pop      (pop_s),
        .head     (head_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s)
    );

    // Tracer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Accepting a halting instruction closes the input; only reset reopens it.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RUN: begin
                if (push_s && ret_halt) begin
                    state_next_s = HALTED;
                end else begin
                    state_next_s = RUN;
                end
            end
            HALTED:  state_next_s = HALTED;
            default: state_next_s = RUN;
        endcase
    end

    // Publish: load the RVVI record and apply the shadow-file write on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvvi_valid    <= 1'b0;
            rvvi_order    <= 64'd0;
            rvvi_insn     <= '0;
            rvvi_trap     <= 1'b0;
            rvvi_halt     <= 1'b0;
            rvvi_intr     <= 1'b0;
            rvvi_mode     <= 2'd0;
            rvvi_pc_rdata <= '0;
            rvvi_pc_wdata <= '0;
            rvvi_x_wb     <= 32'd0;
            shadow_r      <= '0;
            order_cnt_r   <= 64'd0;
            trap_pend_r   <= 1'b0;
        end else if (pop_s) begin
            rvvi_valid    <= 1'b1;
            rvvi_order    <= order_cnt_r;
            order_cnt_r   <= order_cnt_r + 64'd1;
            rvvi_insn     <= head_s.insn[ILEN-1:0];
            rvvi_trap     <= head_s.trap;
            rvvi_halt     <= head_s.halt;
            rvvi_intr     <= trap_pend_r;
            trap_pend_r   <= head_s.trap;
            rvvi_mode     <= head_s.mode;
            rvvi_pc_rdata <= head_s.pc[XLEN-1:0];
            rvvi_pc_wdata <= head_s.next_pc[XLEN-1:0];
            rvvi_x_wb     <= wb_mask(head_s.rd_we, head_s.rd_addr);
            if (head_s.rd_we && (head_s.rd_addr != 5'd0)) begin
                shadow_r[head_s.rd_addr] <= head_s.rd_wdata[XLEN-1:0];
            end
        end else begin
            rvvi_valid <= 1'b0;
            rvvi_x_wb  <= 32'd0;
        end
    end

endmodule

// File: tb/tb_rvvi_retire_tracer.sv
// Randomised scoreboard bench for rvvi_retire_tracer with a queue-based reference model.
module tb_rvvi_retire_tracer;

    localparam int ILEN = 32;
    localparam int XLEN = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  ret_valid;
    logic                  ret_ready;
    logic [ILEN-1:0]       ret_insn;
    logic [XLEN-1:0]       ret_pc;
    logic [XLEN-1:0]       ret_next_pc;
    logic                  ret_trap;
    logic                  ret_halt;
    logic [1:0]            ret_mode;
    logic                  ret_rd_we;
    logic [4:0]            ret_rd_addr;
    logic [XLEN-1:0]       ret_rd_wdata;
    logic                  trc_hold;
    logic                  rvvi_valid;
    logic [63:0]           rvvi_order;
    logic [ILEN-1:0]       rvvi_insn;
    logic                  rvvi_trap;
    logic                  rvvi_halt;
    logic                  rvvi_intr;
    logic [1:0]            rvvi_mode;
    logic [1:0]            rvvi_ixl;
    logic [XLEN-1:0]       rvvi_pc_rdata;
    logic [XLEN-1:0]       rvvi_pc_wdata;
    logic [31:0][XLEN-1:0] rvvi_x_wdata;
    logic [31:0]           rvvi_x_wb;

    always #5 clk = ~clk;

    rvvi_retire_tracer #(.ILEN(ILEN), .XLEN(XLEN), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_insn(ret_insn),
        .ret_pc(ret_pc), .ret_next_pc(ret_next_pc), .ret_trap(ret_trap),
        .ret_halt(ret_halt), .ret_mode(ret_mode), .ret_rd_we(ret_rd_we),
        .ret_rd_addr(ret_rd_addr), .ret_rd_wdata(ret_rd_wdata), .trc_hold(trc_hold),
        .rvvi_valid(rvvi_valid), .rvvi_order(rvvi_order), .rvvi_insn(rvvi_insn),
        .rvvi_trap(rvvi_trap), .rvvi_halt(rvvi_halt), .rvvi_intr(rvvi_intr),
        .rvvi_mode(rvvi_mode), .rvvi_ixl(rvvi_ixl), .rvvi_pc_rdata(rvvi_pc_rdata),
        .rvvi_pc_wdata(rvvi_pc_wdata), .rvvi_x_wdata(rvvi_x_wdata), .rvvi_x_wb(rvvi_x_wb)
    );

    typedef struct {
        logic [63:0]      order;
        logic [31:0]      insn;
        logic [31:0]      pc;
        logic [31:0]      npc;
        logic             trap;
        logic             halt;
        logic             intr;
        logic [1:0]       mode;
        logic [31:0]      x_wb;
        logic [31:0][31:0] xf;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_x [32];
    logic [63:0] m_order = 64'd0;
    bit          m_trap = 1'b0;
    bit          m_halted = 1'b0;
    int          m_occ = 0;
    bit          exp_pop = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model and monitor: model follows the observed handshake, predicts every strobe.
    initial begin
        exp_t e;
        for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
        forever begin
            @(negedge clk);
            chk("rvvi_valid", {63'd0, rvvi_valid}, {63'd0, exp_pop});
            if (rvvi_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_publish actual=order %0h expected=no publish", rvvi_order);
                end else begin
                    e = sb_q.pop_front();
                    m_occ--;
                    chk("order", rvvi_order, e.order);
                    chk("insn", {32'd0, rvvi_insn}, {32'd0, e.insn});
                    chk("pc_rdata", {32'd0, rvvi_pc_rdata}, {32'd0, e.pc});
                    chk("pc_wdata", {32'd0, rvvi_pc_wdata}, {32'd0, e.npc});
                    chk("trap", {63'd0, rvvi_trap}, {63'd0, e.trap});
                    chk("halt", {63'd0, rvvi_halt}, {63'd0, e.halt});
                    chk("intr", {63'd0, rvvi_intr}, {63'd0, e.intr});
                    chk("mode", {62'd0, rvvi_mode}, {62'd0, e.mode});
                    chk("x_wb", {32'd0, rvvi_x_wb}, {32'd0, e.x_wb});
                    checks++;
                    if (rvvi_x_wdata !== e.xf) begin
                        errors++;
                        for (int i = 0; i < 32; i++) begin
                            if (rvvi_x_wdata[i] !== e.xf[i]) begin
                                $display("FAIL x_wdata reg %0d actual=%0h expected=%0h", i, rvvi_x_wdata[i], e.xf[i]);
                                break;
                            end
                        end
                    end
                end
            end else begin
                chk("x_wb_idle", {32'd0, rvvi_x_wb}, 64'd0);
            end
            chk("ret_ready", {63'd0, ret_ready}, {63'd0, (!m_halted && m_occ < 2)});
            exp_pop = !rst && (m_occ > 0) && !trc_hold;
            if (rst) begin
                sb_q.delete();
                m_occ = 0;
                m_halted = 1'b0;
                m_order = 64'd0;
                m_trap = 1'b0;
                for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
            end else if (ret_valid && ret_ready) begin
                if (ret_rd_we && ret_rd_addr != 5'd0) m_x[ret_rd_addr] = ret_rd_wdata;
                e.order = m_order;
                m_order = m_order + 64'd1;
                e.insn = ret_insn;
                e.pc = ret_pc;
                e.npc = ret_next_pc;
                e.trap = ret_trap;
                e.halt = ret_halt;
                e.mode = ret_mode;
                e.intr = m_trap;
                m_trap = ret_trap;
                e.x_wb = (ret_rd_we && ret_rd_addr != 5'd0) ? (32'd1 << ret_rd_addr) : 32'd0;
                for (int i = 0; i < 32; i++) e.xf[i] = m_x[i];
                sb_q.push_back(e);
                m_occ++;
                if (ret_halt) m_halted = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] insn, input logic [31:0] pc, input logic [31:0] npc,
                         input logic trap, input logic halt, input logic [1:0] mode,
                         input logic we, input logic [4:0] rd, input logic [31:0] wd);
        ret_insn = insn; ret_pc = pc; ret_next_pc = npc; ret_trap = trap; ret_halt = halt;
        ret_mode = mode; ret_rd_we = we; ret_rd_addr = rd; ret_rd_wdata = wd;
    endtask

    // Present one event and hold it until accepted (bounded).
    task automatic send(input logic [31:0] insn, input logic [31:0] pc, input logic [31:0] npc,
                        input logic trap, input logic halt, input logic [1:0] mode,
                        input logic we, input logic [4:0] rd, input logic [31:0] wd);
        bit acc;
        int n;
        drive(insn, pc, npc, trap, halt, mode, we, rd, wd);
        ret_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 64) begin
            @(negedge clk);
            acc = ret_ready;
            n++;
            step();
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=not accepted expected=accepted within 64 cycles");
        end
        ret_valid = 1'b0;
    endtask

    task automatic send_rnd(input logic trap, input logic halt);
        logic [31:0] pc;
        pc = {$urandom} & 32'hFFFF_FFFC;
        send($urandom, pc, pc + 32'd4, trap, halt, 2'($urandom_range(3)),
             1'($urandom_range(1)), 5'($urandom_range(31)), $urandom);
    endtask

    initial begin
        rst = 1'b1; ret_valid = 1'b0; trc_hold = 1'b0;
        drive(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 32'd0);
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_order", rvvi_order, 64'd0);
        chk("reset_ixl", {62'd0, rvvi_ixl}, 64'd1);
        chk("reset_x_wdata", {63'd0, |rvvi_x_wdata}, 64'd0);
        chk("reset_pc_rdata", {32'd0, rvvi_pc_rdata}, 64'd0);
        step();

        // First event: strobe exactly two negedges later, gone on the third.
        send(32'h00500093, 32'h80000000, 32'h80000004, 1'b0, 1'b0, 2'd3, 1'b1, 5'd1, 32'd5);
        repeat (2) @(negedge clk);
        chk("t1_valid", {63'd0, rvvi_valid}, 64'd1);
        chk("t1_x_wb", {32'd0, rvvi_x_wb}, 64'h2);
        chk("t1_x1", {32'd0, rvvi_x_wdata[1]}, 64'd5);
        @(negedge clk);
        chk("t1_valid_low", {63'd0, rvvi_valid}, 64'd0);
        chk("t1_x_wb_clear", {32'd0, rvvi_x_wb}, 64'd0);
        step();

        for (int i = 0; i < 4; i++) send_rnd(1'b0, 1'b0);
        repeat (4) step();

        // Hold: two accepts fill the FIFO, third waits for release.
        trc_hold = 1'b1;
        fork
            begin
                for (int i = 0; i < 3; i++) send_rnd(1'b0, 1'b0);
            end
            begin
                repeat (6) step();
                trc_hold = 1'b0;
            end
        join
        repeat (4) step();

        send(32'h00000013, 32'h80000100, 32'h80000104, 1'b0, 1'b0, 2'd3, 1'b1, 5'd0, 32'h0000FFFF);
        send_rnd(1'b1, 1'b0);
        send_rnd(1'b0, 1'b0);
        send_rnd(1'b0, 1'b0);
        send_rnd(1'b1, 1'b0);
        send_rnd(1'b1, 1'b0);
        send_rnd(1'b0, 1'b0);
        repeat (4) step();

        for (int c = 0; c < 400; c++) begin
            logic [31:0] pc;
            pc = {$urandom} & 32'hFFFF_FFFC;
            trc_hold = ($urandom_range(3) == 0);
            ret_valid = 1'($urandom_range(1));
            drive($urandom, pc, pc + 32'd4, ($urandom_range(3) == 0), 1'b0, 2'($urandom_range(3)),
                  1'($urandom_range(1)), 5'($urandom_range(31)), $urandom);
            step();
        end
        ret_valid = 1'b0; trc_hold = 1'b0;
        repeat (6) step();

        // Reset with buffered entries: nothing may publish, order restarts.
        trc_hold = 1'b1;
        send_rnd(1'b0, 1'b0);
        send_rnd(1'b1, 1'b0);
        repeat (2) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0; trc_hold = 1'b0;
        repeat (5) step();
        send_rnd(1'b0, 1'b0);
        repeat (4) step();

        // Halt behind one buffered entry; further events must be refused.
        trc_hold = 1'b1;
        send_rnd(1'b0, 1'b0);
        send_rnd(1'b0, 1'b1);
        ret_valid = 1'b1;
        drive(32'h12345678, 32'h80001000, 32'h80001004, 1'b0, 1'b0, 2'd3, 1'b1, 5'd7, 32'hDEAD);
        repeat (4) step();
        trc_hold = 1'b0;
        repeat (8) step();
        @(negedge clk);
        chk("halted_ready", {63'd0, ret_ready}, 64'd0);
        step();
        ret_valid = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_halt_reset_ready", {63'd0, ret_ready}, 64'd1);
        step();
        send_rnd(1'b0, 1'b0);

        for (int n = 0; n < 20 && sb_q.size() != 0; n++) step();
        repeat (2) step();
        chk("drain", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
